// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel stages and uo_out packing.
// The timing generator drives it through master; consumers read it through slave.
interface vga_timing_gen_if;
    localparam int unsigned CW  = 11;
    localparam int unsigned FCW = 8;

    logic           hsync;
    logic           vsync;
    logic           visible;
    logic [CW-1:0]  pix_x;
    logic [CW-1:0]  pix_y;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_cnt;

    modport master (
        output hsync, vsync, visible, pix_x, pix_y,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        input  hsync, vsync, visible, pix_x, pix_y,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, active flag and strobes.
// Optional frame counter is built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               polarity,
    vga_timing_gen_if.master   vid
);

    localparam int unsigned CW        = 11;
    localparam int unsigned FCW       = 8;
    localparam int unsigned CNT_LIMIT = 2048;
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;

    // Frame dimensions must fit the 11-bit counters.
    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_cfg
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          running;
    logic          line_end;
    logic          frame_end;
    logic          hs_active;
    logic          vs_active;

    assign running   = (state_q == ST_RUN);
    assign line_end  = (x_q == CW'(H_TOTAL - 1));
    assign frame_end = line_end && (y_q == CW'(V_TOTAL - 1));

    // Running tracks enable with one edge of delay; this creates the single hold cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!enable || !running) begin
            x_d = '0;
            y_d = '0;
        end else if (line_end) begin
            x_d = '0;
            y_d = frame_end ? '0 : y_q + CW'(1);
        end else begin
            x_d = x_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Decodes are combinational so polarity and reset reach the pins without an edge.
    assign hs_active = running && (32'(x_q) >= HS_START) && (32'(x_q) < HS_END);
    assign vs_active = running && (32'(y_q) >= VS_START) && (32'(y_q) < VS_END);

    assign vid.pix_x       = x_q;
    assign vid.pix_y       = y_q;
    assign vid.visible     = running && (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
    assign vid.hsync       = hs_active ? polarity : ~polarity;
    assign vid.vsync       = vs_active ? polarity : ~polarity;
    assign vid.line_start  = running && (x_q == '0);
    assign vid.frame_start = running && (x_q == '0) && (y_q == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCW-1:0] fcnt_q, fcnt_d;

    // Scroll phase: advances on the last pixel of each frame, cleared while idle.
    always_comb begin
        fcnt_d = fcnt_q;
        if (!enable) begin
            fcnt_d = '0;
        end else if (running && frame_end) begin
            fcnt_d = fcnt_q + FCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign vid.frame_cnt = fcnt_q;
`else
    assign vid.frame_cnt = '0;
`endif

endmodule
